uart_rx_fifo: RTL

//  - 8N1 UART receiver with a small receive FIFO for the MAX1000 top level.
//  - Samples the board's UART_RXD line and reassembles bytes.
//  - Presents received bytes to the fmrv32im peripheral bus side through a valid/ready interface.
//  - Sits directly downstream of the host serial line, i.e. it consumes the bitstream a host or bench UART drives at 115200 baud.

---
 rtl/uart_rx_fifo.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small receive FIFO and a valid/ready byte output.
// Optional 8E1 framing with live PERR when UART_RX_PARITY_EN is defined.
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 12_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] DATA,
    output logic       VALID,
    input  logic       READY,
    output logic       FERR,
    output logic       OVR,
    output logic       PERR
);

    localparam int unsigned BIT_CYC  = CLK_FREQ / BAUD;
    localparam int unsigned HALF_CYC = BIT_CYC / 2;
    localparam int unsigned CNT_W    = $clog2(BIT_CYC);
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W   = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             state_q;
    logic               rx_meta_q, rxs_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         idx_q;
    logic [7:0]         shift_q;
    logic               ferr_q, ovr_q;
`ifdef UART_RX_PARITY_EN
    logic               par_bad_q, perr_q;
`endif

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr_q, rptr_q, wptr_d, rptr_d;
    logic [FCNT_W-1:0]  count_q, count_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q;

    logic               tick_c, push_c, pop_c, push_ok_c;

    assign tick_c    = (cnt_q == '0);
    assign push_c    = (state_q == S_STOP) && tick_c && rxs_q;
    assign pop_c     = valid_q && READY;
    assign push_ok_c = push_c && ((count_q != FCNT_W'(FIFO_DEPTH)) || pop_c);

    // Two-flop synchroniser on the asynchronous serial line
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= RXD;
            rxs_q     <= rx_meta_q;
        end
    end

    // Frame receiver FSM
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (!rxs_q) begin
                        state_q <= S_START;
                        cnt_q   <= CNT_W'(HALF_CYC - 1);
                    end
                end
                S_START: begin
                    if (!tick_c) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (rxs_q) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q   <= CNT_W'(BIT_CYC - 1);
                        idx_q   <= '0;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!tick_c) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        shift_q <= {rxs_q, shift_q[7:1]};
                        cnt_q   <= CNT_W'(BIT_CYC - 1);
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (!tick_c) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        par_bad_q <= (rxs_q != ^shift_q);
                        cnt_q     <= CNT_W'(BIT_CYC - 1);
                        state_q   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
`ifdef UART_RX_PARITY_EN
                    // Registered so the pulse lands on the stop-tick cycle itself
                    perr_q <= par_bad_q && (cnt_q == CNT_W'(1));
`endif
                    if (!tick_c) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (rxs_q) begin
                        state_q <= S_IDLE;
                    end else begin
                        ferr_q  <= 1'b1;
                        state_q <= S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (rxs_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // FIFO pointer/count/head next-state; head is the byte at rptr_d
    always_comb begin
        wptr_d  = wptr_q + (push_ok_c ? PTR_W'(1) : PTR_W'(0));
        rptr_d  = rptr_q + (pop_c ? PTR_W'(1) : PTR_W'(0));
        count_d = count_q + (push_ok_c ? FCNT_W'(1) : FCNT_W'(0))
                          - (pop_c ? FCNT_W'(1) : FCNT_W'(0));
        data_d  = data_q;
        if (push_ok_c && ((count_q == '0) || ((count_q == FCNT_W'(1)) && pop_c))) begin
            data_d = shift_q;
        end else if (pop_c && (count_d != '0)) begin
            data_d = mem_q[rptr_d];
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok_c) begin
            mem_q[wptr_q] <= shift_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            data_q  <= data_d;
            valid_q <= (count_d != '0);
            ovr_q   <= push_c && !push_ok_c;
        end
    end

    assign DATA  = data_q;
    assign VALID = valid_q;
    assign FERR  = ferr_q;
    assign OVR   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign PERR  = perr_q;
`else
    assign PERR  = 1'b0;
`endif

endmodule
